popcount_argmax: RTL and testbench

- Pipelined, back-pressured successor to the single-cycle bit counter.
- Computes the popcount similarity score of each incoming N-bit vector (XNOR/AND result from the AM datapath) in segmented adder stages.
- Streams each score with its AM address.
- Also tracks the best score and its address across a search sweep delimited by a last flag, so the classifier reads the argmax directly.

---
 rtl/popcount_argmax.sv | 208 ++++++++++++++++++++
 tb/tb_popcount_argmax.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_argmax.sv
// ---------------------------------------------------------------------------
// popcount_argmax
//
// Pipelined, back-pressured popcount scorer for AM similarity vectors.
// Each N-bit input vector is counted in three register stages: input capture,
// per-segment partial counts, then the final sum. Every score leaves with the
// AM address and sweep-last flag that came in with its vector. An argmax
// tracker follows the output stream and publishes the best score and its
// address once per sweep. A sweep ends with the item that has the last flag.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   in_valid_i     input vector valid
//   in_ready_o     block can accept an input this cycle
//   in_data_i      N-bit vector to count
//   in_addr_i      AM address of the vector
//   in_last_i      final vector of the current sweep
//   score_valid_o  score output valid
//   score_ready_i  downstream accepts score
//   score_o        popcount of the vector
//   score_addr_o   address paired with score_o
//   score_last_o   last flag paired with score_o
//   best_valid_o   one-cycle pulse: sweep result valid
//   best_score_o   highest score of the finished sweep
//   best_addr_o    address of the highest score
//
// Optional feature (macro POPCNT_THRESHOLD_EN):
//   thr_i          score threshold
//   hit_o          score_o >= thr_i, registered alongside score_o
// ---------------------------------------------------------------------------
module popcount_argmax #(
    parameter int N             = 2048,
    parameter int SEG_W         = 256,
    parameter int AM_ADDR_WIDTH = 13,
    localparam int SCORE_W      = $clog2(N + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [N-1:0]             in_data_i,
    input  logic [AM_ADDR_WIDTH-1:0] in_addr_i,
    input  logic                     in_last_i,
    output logic                     score_valid_o,
    input  logic                     score_ready_i,
    output logic [SCORE_W-1:0]       score_o,
    output logic [AM_ADDR_WIDTH-1:0] score_addr_o,
    output logic                     score_last_o,
    output logic                     best_valid_o,
    output logic [SCORE_W-1:0]       best_score_o,
    output logic [AM_ADDR_WIDTH-1:0] best_addr_o
`ifdef POPCNT_THRESHOLD_EN
    ,
    input  logic [SCORE_W-1:0]       thr_i,
    output logic                     hit_o
`endif
);

    localparam int NSEG = N / SEG_W;
    localparam int PW   = $clog2(SEG_W + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Popcount of one segment; the result width holds SEG_W itself.
    function automatic logic [PW-1:0] seg_popcount(input logic [SEG_W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < SEG_W; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    // Back-pressure: the only blocking point is an unaccepted score in S3.
    // The whole pipe freezes together, so bubbles are kept as they are.
    logic stall;
    logic advance;
    logic score_xfer;

    assign stall      = score_valid_o && !score_ready_i;
    assign advance    = !stall;
    assign in_ready_o = advance;
    assign score_xfer = score_valid_o && score_ready_i;

    // Stage registers
    logic                     s1_valid;
    logic [N-1:0]             s1_data;
    logic [AM_ADDR_WIDTH-1:0] s1_addr;
    logic                     s1_last;

    logic                     s2_valid;
    logic [NSEG-1:0][PW-1:0]  s2_part;
    logic [AM_ADDR_WIDTH-1:0] s2_addr;
    logic                     s2_last;

    logic [NSEG-1:0][PW-1:0]  seg_count;
    logic [SCORE_W-1:0]       s2_sum;

    // First-level partial counts, one per segment of the captured vector.
    always_comb begin
        seg_count = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg_count[k] = seg_popcount(s1_data[k*SEG_W +: SEG_W]);
        end
    end

    // Second level: zero-extend each partial to the full score width and add.
    always_comb begin
        s2_sum = '0;
        for (int k = 0; k < NSEG; k++) begin
            s2_sum = s2_sum + SCORE_W'(s2_part[k]);
        end
    end

    // Three-stage datapath. Address and last ride alongside the data so
    // every score leaves with its own tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_addr       <= '0;
            s1_last       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_part       <= '0;
            s2_addr       <= '0;
            s2_last       <= 1'b0;
            score_valid_o <= 1'b0;
            score_o       <= '0;
            score_addr_o  <= '0;
            score_last_o  <= 1'b0;
        end else if (advance) begin
            s1_valid      <= in_valid_i;
            s1_data       <= in_data_i;
            s1_addr       <= in_addr_i;
            s1_last       <= in_last_i;
            s2_valid      <= s1_valid;
            s2_part       <= seg_count;
            s2_addr       <= s1_addr;
            s2_last       <= s1_last;
            score_valid_o <= s2_valid;
            score_o       <= s2_sum;
            score_addr_o  <= s2_addr;
            score_last_o  <= s2_last;
        end
    end

`ifdef POPCNT_THRESHOLD_EN
    // The threshold compare is registered together with the score so that
    // hit_o always describes the score currently on score_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_o <= 1'b0;
        end else if (advance) begin
            hit_o <= (s2_sum >= thr_i);
        end
    end
`endif

    // Argmax tracking
    state_t                   state;
    logic [SCORE_W-1:0]       best_score_int;
    logic [AM_ADDR_WIDTH-1:0] best_addr_int;
    logic                     take_new;
    logic [SCORE_W-1:0]       cand_score;
    logic [AM_ADDR_WIDTH-1:0] cand_addr;

    // The first item of a sweep always seeds the best. After that only a
    // strictly larger score replaces it, so ties keep the earlier item.
    always_comb begin
        take_new   = (state == IDLE) || (score_o > best_score_int);
        cand_score = take_new ? score_o : best_score_int;
        cand_addr  = take_new ? score_addr_o : best_addr_int;
    end

    // The FSM moves only on accepted scores. The published outputs change
    // only when a sweep completes. The first item of the next sweep can
    // arrive during the pulse cycle without touching the published result,
    // because it only updates the internal registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            best_score_int <= '0;
            best_addr_int  <= '0;
            best_valid_o   <= 1'b0;
            best_score_o   <= '0;
            best_addr_o    <= '0;
        end else begin
            best_valid_o <= 1'b0;
            if (score_xfer) begin
                best_score_int <= cand_score;
                best_addr_int  <= cand_addr;
                if (score_last_o) begin
                    best_valid_o <= 1'b1;
                    best_score_o <= cand_score;
                    best_addr_o  <= cand_addr;
                    state        <= IDLE;
                end else begin
                    state <= ACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_popcount_argmax.sv
// ---------------------------------------------------------------------------
// tb_popcount_argmax
//
// Directed, table-driven bench for popcount_argmax. Vector records hold the
// stimulus and hand-computed scores and sweep results. A negedge monitor
// compares every accepted score and every best pulse against queues that
// the drivers fill. Also builds with POPCNT_THRESHOLD_EN defined.
// ---------------------------------------------------------------------------
module tb_popcount_argmax;

    localparam int N   = 2048;
    localparam int SEG = 256;
    localparam int AW  = 13;
    localparam int SW  = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_addr;
    logic          in_last;
    logic          score_valid;
    logic          score_ready;
    logic [SW-1:0] score;
    logic [AW-1:0] score_addr;
    logic          score_last;
    logic          best_valid;
    logic [SW-1:0] best_score;
    logic [AW-1:0] best_addr;
`ifdef POPCNT_THRESHOLD_EN
    logic [SW-1:0] thr;
    logic          hit;
`endif

    popcount_argmax #(
        .N(N),
        .SEG_W(SEG),
        .AM_ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .in_addr_i(in_addr),
        .in_last_i(in_last),
        .score_valid_o(score_valid),
        .score_ready_i(score_ready),
        .score_o(score),
        .score_addr_o(score_addr),
        .score_last_o(score_last),
        .best_valid_o(best_valid),
        .best_score_o(best_score),
        .best_addr_o(best_addr)
`ifdef POPCNT_THRESHOLD_EN
        ,
        .thr_i(thr),
        .hit_o(hit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pop;
        int          pat;
        logic [AW-1:0] addr;
        logic        last;
        logic [SW-1:0] exp_score;
        logic        exp_hit;
        logic [SW-1:0] exp_best;
        logic [AW-1:0] exp_best_addr;
    } vec_t;

    typedef struct {
        logic [SW-1:0] score;
        logic [AW-1:0] addr;
        logic          last;
        logic          hit;
    } exp_t;

    typedef struct {
        logic [SW-1:0] score;
        logic [AW-1:0] addr;
    } best_t;

    vec_t  table_v[20];
    exp_t  exp_q[$];
    best_t best_q[$];

    int num_checks = 0;
    int num_errors = 0;

    logic [SW-1:0] exp_pub_score = '0;
    logic [AW-1:0] exp_pub_addr  = '0;

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Pattern 0 sets the low bits, 1 sets the high bits, 2 sets even bits.
    function automatic logic [N-1:0] make_vec(input int pop, input int pat);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < pop; i++) begin
            case (pat)
                0:       v[i] = 1'b1;
                1:       v[N-1-i] = 1'b1;
                default: v[2*i] = 1'b1;
            endcase
        end
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        in_valid = 1'b1;
        in_data  = make_vec(v.pop, v.pat);
        in_addr  = v.addr;
        in_last  = v.last;
    endtask

    task automatic pushExpected(input vec_t v);
        exp_q.push_back('{v.exp_score, v.addr, v.last, v.exp_hit});
        if (v.last) best_q.push_back('{v.exp_best, v.exp_best_addr});
    endtask

    // Stream table entries [first, first+count) with score_ready dropped for
    // stall_len cycles starting at stall_start. While stalled, the head score
    // must be held and input must be refused. Called and returns at posedge+1.
    task automatic run_stream(input int first, input int count, input int stall_start,
                              input int stall_len, input logic [SW-1:0] hold_score,
                              input logic [AW-1:0] hold_addr);
        int idx     = 0;
        int nx      = 0;
        int first_x = -1;
        int last_x  = -1;
        for (int cyc = 0; cyc < count + stall_len + 8; cyc++) begin
            score_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            if (idx < count) applyStimulus(table_v[first + idx]);
            else in_valid = 1'b0;
            @(negedge clk);
            if (score_valid && score_ready) begin
                nx++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            if (!score_ready) begin
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_score", score, hold_score);
                checkOutput("stall_addr", score_addr, hold_addr);
            end
            if (in_valid && in_ready) begin
                pushExpected(table_v[first + idx]);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        score_ready = 1'b1;
        checkOutput("stream_count", nx, count);
        if (stall_len == 0) checkOutput("stream_contiguous", last_x - first_x + 1, count);
    endtask

    // Bounded wait until every expected score and best pulse has been seen.
    task automatic waitDrain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || best_q.size() != 0); i++) begin
            @(negedge clk);
        end
        @(posedge clk); #1;
        checkOutput("drain_scores", exp_q.size(), 0);
        checkOutput("drain_best", best_q.size(), 0);
    endtask

    // Monitor: accepted scores in order, best pulses, and the published best
    // holding its value between pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (score_valid && score_ready) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_errors++;
                    $display("[TB] FAIL unexpected_score: got %0d addr %0d expected none", score, score_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("score", score, e.score);
                    checkOutput("score_addr", score_addr, e.addr);
                    checkOutput("score_last", score_last, e.last);
`ifdef POPCNT_THRESHOLD_EN
                    checkOutput("hit", hit, e.hit);
`endif
                end
            end
            if (best_valid) begin
                if (best_q.size() == 0) begin
                    num_checks++;
                    num_errors++;
                    $display("[TB] FAIL unexpected_best: got %0d addr %0d expected no pulse", best_score, best_addr);
                end else begin
                    best_t b;
                    b = best_q.pop_front();
                    exp_pub_score = b.score;
                    exp_pub_addr  = b.addr;
                end
            end
            checkOutput("best_score", best_score, exp_pub_score);
            checkOutput("best_addr", best_addr, exp_pub_addr);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //             pop   pat addr     last  score  hit   best   best_addr
        table_v[0]  = '{10,   0, 13'd0,    1'b0, 12'd10,   1'b0, 12'd0,    13'd0};
        table_v[1]  = '{300,  1, 13'd1,    1'b0, 12'd300,  1'b0, 12'd0,    13'd0};
        table_v[2]  = '{300,  2, 13'd2,    1'b0, 12'd300,  1'b0, 12'd0,    13'd0};
        table_v[3]  = '{7,    1, 13'd3,    1'b1, 12'd7,    1'b0, 12'd300,  13'd1};
        table_v[4]  = '{256,  1, 13'd20,   1'b0, 12'd256,  1'b0, 12'd0,    13'd0};
        table_v[5]  = '{257,  0, 13'd21,   1'b0, 12'd257,  1'b0, 12'd0,    13'd0};
        table_v[6]  = '{1,    2, 13'd22,   1'b1, 12'd1,    1'b0, 12'd257,  13'd21};
        table_v[7]  = '{1024, 2, 13'd8191, 1'b1, 12'd1024, 1'b1, 12'd1024, 13'd8191};
        table_v[8]  = '{1,    0, 13'd10,   1'b0, 12'd1,    1'b0, 12'd0,    13'd0};
        table_v[9]  = '{2,    1, 13'd11,   1'b1, 12'd2,    1'b0, 12'd2,    13'd11};
        table_v[10] = '{5,    0, 13'd100,  1'b0, 12'd5,    1'b0, 12'd0,    13'd0};
        table_v[11] = '{3,    1, 13'd101,  1'b1, 12'd3,    1'b0, 12'd5,    13'd100};
        table_v[12] = '{511,  0, 13'd30,   1'b0, 12'd511,  1'b0, 12'd0,    13'd0};
        table_v[13] = '{512,  1, 13'd31,   1'b0, 12'd512,  1'b1, 12'd0,    13'd0};
        table_v[14] = '{2048, 0, 13'd32,   1'b1, 12'd2048, 1'b1, 12'd2048, 13'd32};
        table_v[15] = '{50,   0, 13'd1,    1'b0, 12'd50,   1'b0, 12'd0,    13'd0};
        table_v[16] = '{60,   1, 13'd2,    1'b0, 12'd60,   1'b0, 12'd0,    13'd0};
        table_v[17] = '{70,   0, 13'd3,    1'b0, 12'd70,   1'b0, 12'd0,    13'd0};
        table_v[18] = '{80,   1, 13'd4,    1'b0, 12'd80,   1'b0, 12'd0,    13'd0};
        table_v[19] = '{90,   2, 13'd5,    1'b0, 12'd90,   1'b0, 12'd0,    13'd0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_addr     = '0;
        in_last     = 1'b0;
        score_ready = 1'b1;
`ifdef POPCNT_THRESHOLD_EN
        thr         = 12'd512;
`endif

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_score_valid", score_valid, 0);
        checkOutput("rst_best_valid", best_valid, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_best_score", best_score, 0);
        checkOutput("rst_best_addr", best_addr, 0);
        checkOutput("rst_in_ready", in_ready, 1);
`ifdef POPCNT_THRESHOLD_EN
        checkOutput("rst_hit", hit, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: all ones at addr 5, then all zeros at addr 6 closing the sweep
        $display("[TB] latency and extremes");
        exp_q.push_back('{12'd2048, 13'd5, 1'b0, 1'b1});
        exp_q.push_back('{12'd0, 13'd6, 1'b1, 1'b0});
        best_q.push_back('{12'd2048, 13'd5});
        in_valid = 1'b1; in_data = '1; in_addr = 13'd5; in_last = 1'b0;
        @(negedge clk);
        checkOutput("lat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_data = '0; in_addr = 13'd6; in_last = 1'b1;
        @(negedge clk);
        checkOutput("lat_valid_c1", score_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_valid_c2", score_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lat_valid_c3", score_valid, 1);
        checkOutput("lat_score_c3", score, 2048);
        checkOutput("lat_addr_c3", score_addr, 5);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lat_score_c4", score, 0);
        checkOutput("lat_last_c4", score_last, 1);
        @(posedge clk); #1;
        waitDrain();

        // Tie-keeps-first sweep, full rate
        $display("[TB] sweep 10/300/300/7");
        run_stream(0, 4, 0, 0, 12'd0, 13'd0);
        waitDrain();

        // Same sweep with a 5-cycle downstream stall once the pipe is full
        $display("[TB] sweep with stall");
        run_stream(0, 4, 3, 5, 12'd10, 13'd0);
        waitDrain();

        // Segment boundary counts
        $display("[TB] segment boundary sweep");
        run_stream(4, 3, 0, 0, 12'd0, 13'd0);
        waitDrain();

        // Single-item sweep followed at once by a two-item sweep
        $display("[TB] back-to-back sweeps");
        run_stream(7, 3, 0, 0, 12'd0, 13'd0);
        waitDrain();

`ifdef POPCNT_THRESHOLD_EN
        $display("[TB] threshold 512");
        run_stream(12, 3, 0, 0, 12'd0, 13'd0);
        waitDrain();
`endif

        // Reset with three items in flight and the tracker mid-sweep
        $display("[TB] reset mid-sweep");
        score_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(table_v[15 + i]);
            @(negedge clk);
            if (i < 2) pushExpected(table_v[15 + i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_score_valid", score_valid, 0);
        checkOutput("mid_rst_best_valid", best_valid, 0);
        checkOutput("mid_rst_best_score", best_score, 0);
        checkOutput("mid_rst_best_addr", best_addr, 0);
        checkOutput("mid_rst_scores_seen", exp_q.size(), 0);
        exp_pub_score = '0;
        exp_pub_addr  = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_stream(10, 2, 0, 0, 12'd0, 13'd0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
